// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive FIFO between a UART receiver and a CPU register port.
//   Each rising edge of receive_flag pushes rx_data, so the flag may be a
//   single-cycle pulse or held high. The CPU pops the head by reading
//   DATA_ADDR. It reads status and writes control at STAT_ADDR.
//   All state changes on the falling edge of clk, which is the same edge the
//   UART block uses. The reset is synchronous and active-high.
//
// Ports
//   clk, reset    clock (falling-edge active), synchronous active-high reset
//   rx_data       received byte, valid while receive_flag is high
//   receive_flag  receive-complete indication (level or pulse)
//   access_addr   CPU register address
//   reg_r_en      CPU read strobe; a DATA_ADDR read pops the head
//   reg_w_en      CPU write strobe
//   reg_w_data    CPU write data
//   rd_data       combinational register read data
//   count         current occupancy
//   empty, full   occupancy flags
//   overflow      sticky: a byte was dropped because the FIFO was full
//   int_req       registered interrupt request
//
// Register map
//   DATA_ADDR read : head byte (8'h00 when empty); the read also pops
//   STAT_ADDR read : {overflow, full, empty, int_en, count[3:0] saturating}
//   STAT_ADDR write: bit0 -> int_en, bit7 = 1 clears overflow
module uart_rx_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  DATA_ADDR = 8'd253,
  parameter logic [7:0]  STAT_ADDR = 8'd254,
  parameter int          THRESHOLD = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     receive_flag,
  input  logic [7:0]               access_addr,
  input  logic                     reg_r_en,
  input  logic                     reg_w_en,
  input  logic [7:0]               reg_w_data,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     int_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          prev_flag;
  logic          int_en;

  logic          push;
  logic          pop;
  logic          do_write;
  logic          ovf_set;
  logic          stat_wr;
  logic [CW-1:0] count_next;
  logic [31:0]   count_ext;
  logic [3:0]    count4;

  // Only bits 0 and 7 of a status write carry meaning.
  logic          unused_w_bits;
  assign unused_w_bits = ^reg_w_data[6:1];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // The push fires once for each receive_flag assertion. The flag history
  // register resets to 1. A flag that is already high at reset release is
  // therefore not taken as a new byte.
  assign push = receive_flag && !prev_flag;
  assign pop  = reg_r_en && (access_addr == DATA_ADDR) && !empty;

  // When the FIFO is full and a pop happens on the same edge, the write
  // lands in the slot the pop frees. In that case wr_ptr == rd_ptr, and
  // the head byte has already been presented on rd_data during this cycle.
  assign do_write = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign stat_wr  = reg_w_en && (access_addr == STAT_ADDR);

  assign count_next = count + (do_write ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));

  // The 4-bit count field saturates when DEPTH is larger than 15.
  assign count_ext = 32'(count);
  assign count4    = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    rd_data = 8'h00;
    if (access_addr == DATA_ADDR) begin
      rd_data = empty ? 8'h00 : mem[rd_ptr];
    end else if (access_addr == STAT_ADDR) begin
      rd_data = {overflow, full, empty, int_en, count4};
    end
  end

  // The storage array is not reset. Reset only clears the pointers, so the
  // old contents become unreachable.
  always_ff @(negedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prev_flag <= 1'b1;
      overflow  <= 1'b0;
      int_en    <= 1'b0;
      int_req   <= 1'b0;
    end else begin
      prev_flag <= receive_flag;
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      // When a set and a clear of overflow fall on the same edge, the set wins.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (stat_wr && reg_w_data[7]) begin
        overflow <= 1'b0;
      end
      if (stat_wr) int_en <= reg_w_data[0];
      // int_req uses the int_en value held before this edge. Clearing
      // int_en therefore drops the request one edge later.
      int_req <= int_en && (count_next >= CW'(THRESHOLD));
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo with the default parameters
//   (DEPTH 8, DATA_ADDR 253, STAT_ADDR 254, THRESHOLD 1).
//   The DUT updates on the falling edge. Inputs are driven, and outputs
//   sampled, 1 time unit after each falling edge. rd_data is combinational
//   and is sampled before the edge that consumes it.
module tb_uart_rx_fifo;

  localparam logic [7:0] DATA_A = 8'd253;
  localparam logic [7:0] STAT_A = 8'd254;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       receive_flag;
  logic [7:0] access_addr;
  logic       reg_r_en;
  logic       reg_w_en;
  logic [7:0] reg_w_data;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       int_req;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .receive_flag (receive_flag),
    .access_addr  (access_addr),
    .reg_r_en     (reg_r_en),
    .reg_w_en     (reg_w_en),
    .reg_w_data   (reg_w_data),
    .rd_data      (rd_data),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .int_req      (int_req)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one falling (active) edge and settle.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Hold receive_flag for 'hold' edges; the byte is taken on the first one.
  task automatic push_byte(input logic [7:0] b, input int hold);
    rx_data      = b;
    receive_flag = 1'b1;
    repeat (hold) cyc();
    receive_flag = 1'b0;
    cyc();
  endtask

  task automatic read_data(input string tag, input logic [7:0] exp);
    access_addr = DATA_A;
    reg_r_en    = 1'b1;
    #1;
    check(tag, rd_data, exp);
    cyc();
    reg_r_en = 1'b0;
  endtask

  task automatic read_stat(input string tag, input logic [7:0] exp);
    access_addr = STAT_A;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic write_stat(input logic [7:0] v);
    access_addr = STAT_A;
    reg_w_data  = v;
    reg_w_en    = 1'b1;
    cyc();
    reg_w_en = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    rx_data      = 8'h00;
    receive_flag = 1'b0;
    access_addr  = 8'h00;
    reg_r_en     = 1'b0;
    reg_w_en     = 1'b0;
    reg_w_data   = 8'h00;
    #1;
    do_reset();

    // reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_int", int_req, 0);
    read_stat("rst_stat", 8'h20);
    access_addr = 8'h10;
    #1;
    check("other_addr", rd_data, 8'h00);

    // single push with a long flag, then one read
    push_byte(8'hA5, 3);
    check("a5_count", count, 1);
    check("a5_empty", empty, 0);
    read_data("a5_data", 8'hA5);
    check("a5_count_after", count, 0);
    check("a5_empty_after", empty, 1);

    // overfill: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) push_byte(8'(i), 1);
    check("of_full", full, 1);
    check("of_ovf", overflow, 1);
    check("of_count", count, 8);
    read_stat("of_stat", 8'hC8);
    write_stat(8'h00);
    check("of_ovf_kept", overflow, 1);
    for (int i = 1; i <= 8; i++) read_data($sformatf("of_rd%0d", i), 8'(i));
    check("of_drained", empty, 1);
    write_stat(8'h80);
    check("of_ovf_clr", overflow, 0);
    read_stat("of_stat_clr", 8'h20);

    // full FIFO: push and pop on the same edge
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1);
    check("fp_full", full, 1);
    rx_data      = 8'h55;
    receive_flag = 1'b1;
    access_addr  = DATA_A;
    reg_r_en     = 1'b1;
    #1;
    check("fp_head", rd_data, 8'h10);
    cyc();
    reg_r_en     = 1'b0;
    receive_flag = 1'b0;
    check("fp_count", count, 8);
    check("fp_ovf", overflow, 0);
    cyc();
    for (int i = 1; i < 8; i++) read_data($sformatf("fp_rd%0d", i), 8'h10 + 8'(i));
    read_data("fp_rd8", 8'h55);
    check("fp_empty", empty, 1);

    // interrupt enable, assertion and deassertion
    write_stat(8'h01);
    check("int_idle", int_req, 0);
    rx_data      = 8'h3C;
    receive_flag = 1'b1;
    cyc();
    receive_flag = 1'b0;
    check("int_set", int_req, 1);
    cyc();
    read_stat("int_stat", 8'h11);
    read_data("int_data", 8'h3C);
    check("int_clr_pop", int_req, 0);
    push_byte(8'h3D, 1);
    check("int_set2", int_req, 1);
    write_stat(8'h00);
    check("int_lag", int_req, 1);
    cyc();
    check("int_clr_en", int_req, 0);
    read_data("int_data2", 8'h3D);

    // read while empty leaves everything alone
    read_data("emp_rd", 8'h00);
    check("emp_count", count, 0);
    check("emp_flag", empty, 1);
    check("emp_ovf", overflow, 0);

    // ten push/read rounds walk the pointers across the wrap point
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h80 + 8'(i), 1);
      read_data($sformatf("wrap%0d", i), 8'h80 + 8'(i));
    end
    check("wrap_empty", empty, 1);

    // reset mid-operation, with receive_flag held across the release
    write_stat(8'h01);
    push_byte(8'hB1, 1);
    push_byte(8'hB2, 1);
    push_byte(8'hB3, 1);
    check("mr_count_pre", count, 3);
    check("mr_int_pre", int_req, 1);
    rx_data      = 8'hEE;
    receive_flag = 1'b1;
    reset        = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    check("mr_count", count, 0);
    check("mr_empty", empty, 1);
    check("mr_int", int_req, 0);
    read_stat("mr_stat", 8'h20);
    receive_flag = 1'b0;
    cyc();
    push_byte(8'h77, 1);
    check("mr_count_post", count, 1);
    read_data("mr_data", 8'h77);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..128.
REQ-002 Parameter DATA_ADDR, default 8'd253, read-data register address.
REQ-003 Parameter STAT_ADDR, default 8'd254, status/control register address.
REQ-004 Parameter THRESHOLD, default 1, occupancy at or above which int_req asserts; range 1..DEPTH.
REQ-005 clk  input  1  single clock; all state updates on falling edge of clk, same edge as the UART block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_data  input  8  received byte from UART receiver, valid while receive_flag high.
REQ-008 receive_flag  input  1  UART receive-complete indication, level or pulse.
REQ-009 access_addr  input  8  CPU register address.
REQ-010 reg_r_en  input  1  CPU read strobe, one cycle per read.
REQ-011 reg_w_en  input  1  CPU write strobe.
REQ-012 reg_w_data  input  8  CPU write data.
REQ-013 rd_data  output  8  combinational register read data.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 empty  output  1  count == 0.
REQ-016 full  output  1  count == DEPTH.
REQ-017 overflow  output  1  sticky: byte dropped because FIFO was full.
REQ-018 int_req  output  1  registered interrupt request to CPU.

Function
REQ-019 Push condition: receive_flag==1 and registered previous receive_flag==0 (rising-edge detect); exactly one push per receive_flag assertion, regardless of assertion length.
REQ-020 On push with FIFO not full, rx_data written at write pointer; write pointer increments modulo DEPTH.
REQ-021 Pop condition: reg_r_en==1, access_addr==DATA_ADDR, empty==0; read pointer increments modulo DEPTH.
REQ-022 Pop with empty==1 has no effect on pointers, count or flags.
REQ-023 Push and pop in same edge when not empty: both performed, count unchanged, including when full (no overflow).
REQ-024 Push and pop in same edge when empty: push only, count becomes 1.
REQ-025 Push when full without pop: byte discarded, memory and pointers unchanged, overflow set to 1.
REQ-026 Latency: a pushed byte is visible at head and reflected in count/empty after the pushing edge; readable from the following cycle.
REQ-027 rd_data when access_addr==DATA_ADDR: head entry if not empty, else 8'h00; value presented is the byte consumed by a pop in that cycle.
REQ-028 rd_data when access_addr==STAT_ADDR: {overflow, full, empty, int_en, count zero-extended/truncated to 4 bits}; for DEPTH>8 bits[3:0] saturate at 4'hF.
REQ-029 rd_data for any other address: 8'h00.
REQ-030 Write with reg_w_en==1, access_addr==STAT_ADDR: int_en <= reg_w_data[0]; reg_w_data[7]==1 clears overflow; bit7==0 leaves overflow unchanged.
REQ-031 Overflow set and clear in same edge: set wins, overflow stays 1.
REQ-032 Writes to DATA_ADDR ignored.
REQ-033 int_req registered: int_req <= int_en && (count_next >= THRESHOLD), where count_next is occupancy after this edge's push/pop.
REQ-034 int_req deasserts the edge after the pop that drops occupancy below THRESHOLD, or the edge after int_en cleared.

Reset
REQ-035 On reset: read/write pointers 0, count 0, empty 1, full 0, overflow 0, int_en 0, int_req 0; FIFO memory contents not reset.
REQ-036 On reset the previous-receive_flag register is set to 1, so a receive_flag already high at reset release produces no push.
REQ-037 Reset mid-operation discards all stored bytes; reset has priority over push, pop and register writes on the same edge.

Verification
REQ-038 Push 8'hA5 (receive_flag high 3 cycles) -> count=1, empty=0; DATA_ADDR read returns 8'hA5 then count=0, empty=1.
REQ-039 Push 9 bytes 8'h01..8'h09 into DEPTH=8 -> full=1, overflow=1, count=8; 8 reads return 8'h01..8'h08; STAT write 8'h80 clears overflow.
REQ-040 Full FIFO, push 8'h55 and pop same edge -> count stays 8, overflow=0, 8'h55 returned as 8th subsequent read.
REQ-041 STAT write 8'h01, push one byte -> int_req=1 next edge; read byte -> int_req=0 next edge; STAT read shows int_en=1.
REQ-042 Read DATA_ADDR while empty -> rd_data=8'h00, pointers unchanged; 10 push/pop cycles verify pointer wrap preserves order.
REQ-043 Push 3 bytes, assert reset -> count=0, empty=1, int_req=0; receive_flag held high across reset release -> no push.
